// File: rtl/ysyx_22041071_pipe_ctrl.sv
// rtl/ysyx_22041071_pipe_ctrl.sv - pipeline hold/flush/bubble controller (optional counters: YSYX_22041071_PERF_CNT_EN)
module ysyx_22041071_pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic        ex_reg_w_en,
    input  logic [4:0]  ex_rdest,
    input  logic        redirect,
    input  logic        mem_busy,
    input  logic        if_busy,
    output logic        pc_hold,
    output logic        pc_redirect,
    output logic        if_id_hold,
    output logic        if_id_flush,
    output logic        id_ex_hold,
    output logic        id_ex_bubble,
    output logic        ex_mem_hold,
    output logic        mem_timeout,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] freeze_cnt
);

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_FREEZE} state_t;

    // Last value of flush_ctr before returning to RUN; unused when FLUSH_CYCLES is 1.
    localparam logic [2:0]  LP_FLUSH_LAST = 3'(FLUSH_CYCLES - 2);
    localparam logic [15:0] LP_TIMEOUT    = 16'(MEM_TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_flush_ctr;
    logic [2:0]  w_flush_ctr_nxt;
    logic [15:0] r_freeze_ctr;
    logic [15:0] w_freeze_ctr_nxt;
    logic        r_pend_redir;
    logic        w_pend_redir_nxt;
    logic        r_mem_timeout;
    logic        w_lu;

    assign w_lu = id_valid & ex_valid & ex_is_load & ex_reg_w_en & (ex_rdest != 5'd0) &
                  ((id_use_rs1 & (id_rs1 == ex_rdest)) | (id_use_rs2 & (id_rs2 == ex_rdest)));

    assign mem_timeout = r_mem_timeout;

    // Next-state and control outputs; the stalled-memory holds override every other action.
    always_comb begin
        pc_hold          = 1'b0;
        pc_redirect      = 1'b0;
        if_id_hold       = 1'b0;
        if_id_flush      = 1'b0;
        id_ex_hold       = 1'b0;
        id_ex_bubble     = 1'b0;
        ex_mem_hold      = 1'b0;
        w_state_nxt      = r_state;
        w_flush_ctr_nxt  = r_flush_ctr;
        w_freeze_ctr_nxt = r_freeze_ctr;
        w_pend_redir_nxt = r_pend_redir;
        if (reset) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (mem_busy) begin
                        {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold} = 4'b1111;
                        w_pend_redir_nxt = redirect;
                        w_freeze_ctr_nxt = 16'd1;
                        w_state_nxt      = ST_FREEZE;
                    end else if (redirect) begin
                        {pc_redirect, if_id_flush, id_ex_bubble} = 3'b111;
                        if (FLUSH_CYCLES > 1) begin
                            w_state_nxt     = ST_FLUSH;
                            w_flush_ctr_nxt = 3'd0;
                        end
                    end else if (w_lu) begin
                        {pc_hold, if_id_hold, id_ex_bubble} = 3'b111;
                    end else if (if_busy) begin
                        {pc_hold, if_id_flush} = 2'b11;
                    end
                end
                ST_FLUSH: begin
                    if (mem_busy) begin
                        {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold} = 4'b1111;
                    end else begin
                        {if_id_flush, id_ex_bubble} = 2'b11;
                        pc_hold = if_busy;
                        if (r_flush_ctr == LP_FLUSH_LAST) begin
                            w_state_nxt     = ST_RUN;
                            w_flush_ctr_nxt = 3'd0;
                        end else begin
                            w_flush_ctr_nxt = r_flush_ctr + 3'd1;
                        end
                    end
                end
                ST_FREEZE: begin
                    if (mem_busy) begin
                        {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold} = 4'b1111;
                        w_pend_redir_nxt = r_pend_redir | redirect;
                        if (r_freeze_ctr != LP_TIMEOUT) begin
                            w_freeze_ctr_nxt = r_freeze_ctr + 16'd1;
                        end
                    end else begin
                        w_freeze_ctr_nxt = 16'd0;
                        w_pend_redir_nxt = 1'b0;
                        w_state_nxt      = ST_RUN;
                        if (r_pend_redir | redirect) begin
                            {pc_redirect, if_id_flush, id_ex_bubble} = 3'b111;
                            if (FLUSH_CYCLES > 1) begin
                                w_state_nxt     = ST_FLUSH;
                                w_flush_ctr_nxt = 3'd0;
                            end
                        end else if (w_lu) begin
                            {pc_hold, if_id_hold, id_ex_bubble} = 3'b111;
                        end else if (if_busy) begin
                            {pc_hold, if_id_flush} = 2'b11;
                        end
                    end
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    // State, counters and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_flush_ctr   <= 3'd0;
            r_freeze_ctr  <= 16'd0;
            r_pend_redir  <= 1'b0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_ctr  <= w_flush_ctr_nxt;
            r_freeze_ctr <= w_freeze_ctr_nxt;
            r_pend_redir <= w_pend_redir_nxt;
            if (w_freeze_ctr_nxt == LP_TIMEOUT) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

`ifdef YSYX_22041071_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_freeze_cnt;

    // A load-use stall is the only action that both holds IF/ID and bubbles ID/EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt  <= 32'd0;
            r_flush_cnt  <= 32'd0;
            r_freeze_cnt <= 32'd0;
        end else begin
            if (if_id_hold & id_ex_bubble) r_stall_cnt  <= r_stall_cnt + 32'd1;
            if (pc_redirect)               r_flush_cnt  <= r_flush_cnt + 32'd1;
            if (r_state == ST_FREEZE)      r_freeze_cnt <= r_freeze_cnt + 32'd1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;
    assign freeze_cnt = r_freeze_cnt;
`else
    assign stall_cnt  = 32'd0;
    assign flush_cnt  = 32'd0;
    assign freeze_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ysyx_22041071_pipe_ctrl.sv
// tb/tb_ysyx_22041071_pipe_ctrl.sv - directed self-checking bench for ysyx_22041071_pipe_ctrl
module tb_ysyx_22041071_pipe_ctrl;

    localparam logic [6:0] C_NONE  = 7'h00;
    localparam logic [6:0] C_HOLDS = 7'h55;
    localparam logic [6:0] C_REDIR = 7'h2A;
    localparam logic [6:0] C_LU    = 7'h52;
    localparam logic [6:0] C_IFB   = 7'h48;
    localparam logic [6:0] C_FL    = 7'h0A;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_use_rs1, id_use_rs2;
    logic [4:0]  id_rs1, id_rs2, ex_rdest;
    logic        ex_valid, ex_is_load, ex_reg_w_en;
    logic        redirect, mem_busy, if_busy;
    logic        pc_hold, pc_redirect, if_id_hold, if_id_flush;
    logic        id_ex_hold, id_ex_bubble, ex_mem_hold, mem_timeout;
    logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
    logic [6:0]  ctl;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_hold, pc_redirect, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_hold};

    ysyx_22041071_pipe_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_reg_w_en(ex_reg_w_en),
        .ex_rdest(ex_rdest), .redirect(redirect), .mem_busy(mem_busy), .if_busy(if_busy),
        .pc_hold(pc_hold), .pc_redirect(pc_redirect), .if_id_hold(if_id_hold),
        .if_id_flush(if_id_flush), .id_ex_hold(id_ex_hold), .id_ex_bubble(id_ex_bubble),
        .ex_mem_hold(ex_mem_hold), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ec(input int n);
`ifdef YSYX_22041071_PERF_CNT_EN
        return 32'(n);
`else
        return 32'd0 & 32'(n);
`endif
    endfunction

    task automatic clear_inputs();
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
        ex_valid = 0; ex_is_load = 0; ex_reg_w_en = 0; ex_rdest = 0;
        redirect = 0; mem_busy = 0; if_busy = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
        id_valid = 1; ex_valid = 1; ex_is_load = 1; ex_reg_w_en = 1;
        ex_rdest = rd; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    endtask

    // Check the control outputs for the current inputs, then advance one cycle.
    task automatic step(input string tag, input logic [6:0] exp);
        #1;
        check(tag, {25'd0, ctl}, {25'd0, exp});
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        @(negedge clk);
        step("rst_ctl", C_FL);
        reset = 0;
        #1;
        check("rst_timeout", {31'd0, mem_timeout}, 32'd0);
        check("rst_stall", stall_cnt, 32'd0);
        check("rst_freeze", freeze_cnt, 32'd0);
        step("idle", C_NONE);

        set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        step("lu_rs1", C_LU);
        clear_inputs();
        step("lu_after", C_NONE);
        check("lu_stall_cnt", stall_cnt, ec(1));
        set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        step("lu_rd0", C_NONE);
        set_lu(5'd5, 5'd5, 1'b0, 5'd0, 1'b0);
        step("lu_nouse", C_NONE);
        set_lu(5'd9, 5'd1, 1'b1, 5'd9, 1'b1);
        step("lu_rs2", C_LU);
        ex_is_load = 0;
        step("lu_noload", C_NONE);
        clear_inputs();
        check("lu_stall_cnt2", stall_cnt, ec(2));

        if_busy = 1;
        step("if_busy", C_IFB);
        clear_inputs();
        step("if_busy_after", C_NONE);

        redirect = 1;
        step("redir_c1", C_REDIR);
        redirect = 0;
        step("redir_c2", C_FL);
        step("redir_c3", C_FL);
        step("redir_c4", C_NONE);
        check("redir_flush_cnt", flush_cnt, ec(1));

        mem_busy = 1;
        step("frz_c1", C_HOLDS);
        redirect = 1;
        step("frz_c2", C_HOLDS);
        redirect = 0;
        step("frz_c3", C_HOLDS);
        step("frz_c4", C_HOLDS);
        mem_busy = 0;
        step("frz_c5", C_REDIR);
        step("frz_c6", C_FL);
        step("frz_c7", C_FL);
        step("frz_c8", C_NONE);
        check("frz_freeze_cnt", freeze_cnt, ec(4));
        check("frz_flush_cnt", flush_cnt, ec(2));
        check("frz_timeout", {31'd0, mem_timeout}, 32'd0);

        set_lu(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
        redirect = 1;
        step("redir_lu", C_REDIR);
        clear_inputs();
        step("redir_lu_c2", C_FL);
        step("redir_lu_c3", C_FL);
        check("redir_lu_stall", stall_cnt, ec(2));

        mem_busy = 1;
        step("frz_lu_c1", C_HOLDS);
        mem_busy = 0;
        set_lu(5'd3, 5'd0, 1'b0, 5'd3, 1'b1);
        step("frz_lu_exit", C_LU);
        clear_inputs();
        step("frz_lu_after", C_NONE);
        check("frz_lu_stall", stall_cnt, ec(3));
        check("frz_lu_freeze", freeze_cnt, ec(5));

        redirect = 1;
        step("fl_busy_c1", C_REDIR);
        redirect = 0;
        mem_busy = 1;
        step("fl_busy_c2", C_HOLDS);
        mem_busy = 0;
        step("fl_busy_c3", C_FL);
        step("fl_busy_c4", C_FL);
        step("fl_busy_c5", C_NONE);
        check("fl_busy_flush_cnt", flush_cnt, ec(4));
        check("fl_busy_freeze_cnt", freeze_cnt, ec(5));

        for (int i = 1; i <= 10; i++) begin
            mem_busy = 1;
            #1;
            check($sformatf("tmo_c%0d", i), {31'd0, mem_timeout}, (i >= 9) ? 32'd1 : 32'd0);
            step($sformatf("tmo_ctl%0d", i), C_HOLDS);
        end
        mem_busy = 0;
        step("tmo_exit", C_NONE);
        #1;
        check("tmo_sticky", {31'd0, mem_timeout}, 32'd1);
        check("tmo_freeze_cnt", freeze_cnt, ec(15));
        reset = 1;
        step("tmo_rst", C_FL);
        reset = 0;
        #1;
        check("tmo_cleared", {31'd0, mem_timeout}, 32'd0);
        check("tmo_rst_flush_cnt", flush_cnt, 32'd0);

        mem_busy = 1;
        redirect = 1;
        step("pend_c1", C_HOLDS);
        clear_inputs();
        reset = 1;
        step("pend_rst", C_FL);
        reset = 0;
        step("pend_discard", C_NONE);
        step("pend_idle", C_NONE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
